barrel_shift_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter for the ALU shift path; successor to the fixed
//  16-bit logical right shifter. Ops: SRL/SLL/SRA/ROR/ROL with carry-out and zero flag.

---
 rtl/barrel_shift_pipe_pkg.sv | 29 ++
 rtl/barrel_shift_pipe_level.sv | 96 +++++++++
 rtl/barrel_shift_pipe.sv | 150 +++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Op encodings and small op-classification helpers.
package barrel_shift_pipe_pkg;

    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SLL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } shift_op_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

    function automatic logic op_is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic op_is_rotate(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return op == OP_SRA;
    endfunction

endpackage

// File: rtl/barrel_shift_pipe_level.sv
// One right-shift mux level (shift by SHIFT) with fill and carry tracking.
// Optionally registered with a valid/ready stall slot.
module shift_level
    import barrel_shift_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1,
    parameter int REG   = 1,
    parameter int SHW   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_carry,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic [2:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_carry,
    output logic             out_err
);

    localparam int LVL = $clog2(SHIFT);

    logic [SHIFT-1:0] fill;
    logic [WIDTH-1:0] data_n;
    logic             carry_n;

    // Shift by SHIFT when this level's shamt bit is set; last bit out becomes carry.
    always_comb begin
        fill = '0;
        if (op_is_rotate(in_op)) begin
            fill = in_data[SHIFT-1:0];
        end else if (op_is_arith(in_op)) begin
            fill = {SHIFT{in_data[WIDTH-1]}};
        end
        data_n  = in_data;
        carry_n = in_carry;
        if (in_shamt[LVL]) begin
            data_n  = {fill, in_data[WIDTH-1:SHIFT]};
            carry_n = in_data[SHIFT-1];
        end
    end

    if (REG != 0) begin : g_reg
        logic full;

        assign in_ready  = !full || out_ready;
        assign out_valid = full;

        // Pipeline slot: load when empty or when the downstream takes our op.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                full      <= 1'b0;
                out_data  <= '0;
                out_shamt <= '0;
                out_op    <= '0;
                out_tag   <= '0;
                out_carry <= 1'b0;
                out_err   <= 1'b0;
            end else if (in_ready) begin
                full <= in_valid;
                if (in_valid) begin
                    out_data  <= data_n;
                    out_shamt <= in_shamt;
                    out_op    <= in_op;
                    out_tag   <= in_tag;
                    out_carry <= carry_n;
                    out_err   <= in_err;
                end
            end
        end
    end else begin : g_comb
        logic unused_clk;

        assign unused_clk = clk ^ rst;
        assign in_ready   = out_ready;
        assign out_valid  = in_valid;
        assign out_data   = data_n;
        assign out_shamt  = in_shamt;
        assign out_op     = in_op;
        assign out_tag    = in_tag;
        assign out_carry  = carry_n;
        assign out_err    = in_err;
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SRL/SLL/SRA/ROR/ROL with carry, zero and error flags.
// Left ops run through the right-shift levels on bit-reversed data.
module barrel_shift_pipe
    import barrel_shift_pipe_pkg::*;
#(
    parameter int  WIDTH     = 16,
    parameter int  PIPELINED = 1,
    parameter int  TAG_W     = 4,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH-1:0] rev_in;
    logic [WIDTH-1:0] head_data;
    logic [SHW-1:0]   head_shamt;
    logic             head_err;
    logic             tail_ready;

    // Bit-reverse the operand so left ops can use the right-shift levels.
    always_comb begin
        rev_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_in[i] = in_data[WIDTH-1-i];
        end
    end

    assign head_data  = op_is_left(in_op) ? rev_in : in_data;
    assign head_shamt = op_is_legal(in_op) ? in_shamt : '0;
    assign head_err   = !op_is_legal(in_op);

    for (genvar k = 0; k < SHW; k++) begin : g_lv
        logic             vi, ri, vo, ro;
        logic             ci, ei, co, eo;
        logic [WIDTH-1:0] di, dq;
        logic [SHW-1:0]   si, sq;
        logic [2:0]       oi, oq;
        logic [TAG_W-1:0] ti, tq;

        if (k == 0) begin : g_head
            assign vi = in_valid;
            assign di = head_data;
            assign si = head_shamt;
            assign oi = in_op;
            assign ti = in_tag;
            assign ci = 1'b0;
            assign ei = head_err;
        end else begin : g_link
            assign vi = g_lv[k-1].vo;
            assign di = g_lv[k-1].dq;
            assign si = g_lv[k-1].sq;
            assign oi = g_lv[k-1].oq;
            assign ti = g_lv[k-1].tq;
            assign ci = g_lv[k-1].co;
            assign ei = g_lv[k-1].eo;
        end

        if (k == SHW - 1) begin : g_tail
            assign ro = tail_ready;
        end else begin : g_mid
            assign ro = g_lv[k+1].ri;
        end

        shift_level #(
            .WIDTH(WIDTH),
            .SHIFT(1 << k),
            .REG  ((PIPELINED != 0 && k < SHW - 1) ? 1 : 0),
            .SHW  (SHW),
            .TAG_W(TAG_W)
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .in_valid (vi),
            .in_ready (ri),
            .in_data  (di),
            .in_shamt (si),
            .in_op    (oi),
            .in_tag   (ti),
            .in_carry (ci),
            .in_err   (ei),
            .out_valid(vo),
            .out_ready(ro),
            .out_data (dq),
            .out_shamt(sq),
            .out_op   (oq),
            .out_tag  (tq),
            .out_carry(co),
            .out_err  (eo)
        );
    end

    assign in_ready = g_lv[0].ri;

    logic             tail_valid;
    logic [WIDTH-1:0] tail_data;
    logic [WIDTH-1:0] rev_out;
    logic [WIDTH-1:0] final_data;
    logic             unused_shamt;

    assign tail_valid   = g_lv[SHW-1].vo;
    assign tail_data    = g_lv[SHW-1].dq;
    assign unused_shamt = ^g_lv[SHW-1].sq;
    assign tail_ready   = !out_valid || out_ready;

    // Undo the bit reversal for left ops.
    always_comb begin
        rev_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_out[i] = tail_data[WIDTH-1-i];
        end
    end

    assign final_data = op_is_left(g_lv[SHW-1].oq) ? rev_out : tail_data;

    // Output register: holds the result and its flags stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
            out_tag   <= '0;
        end else if (tail_ready) begin
            out_valid <= tail_valid;
            if (tail_valid) begin
                out_data  <= final_data;
                out_carry <= g_lv[SHW-1].co;
                out_zero  <= (final_data == '0);
                out_err   <= g_lv[SHW-1].eo;
                out_tag   <= g_lv[SHW-1].tq;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe, PIPELINED=1 (index 0) and 0 (index 1).
// Directed vectors, reset flush, and random ops vs an arithmetic reference model.
module tb_barrel_shift_pipe;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [W-1:0]  in_data   [2];
    logic [SW-1:0] in_shamt  [2];
    logic [2:0]    in_op     [2];
    logic [TW-1:0] in_tag    [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [W-1:0]  out_data  [2];
    logic          out_carry [2];
    logic          out_zero  [2];
    logic          out_err   [2];
    logic [TW-1:0] out_tag   [2];

    barrel_shift_pipe #(.WIDTH(W), .PIPELINED(1), .TAG_W(TW)) u_pipe (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_shamt(in_shamt[0]),
        .in_op(in_op[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_carry(out_carry[0]),
        .out_zero(out_zero[0]), .out_err(out_err[0]),
        .out_tag(out_tag[0])
    );

    barrel_shift_pipe #(.WIDTH(W), .PIPELINED(0), .TAG_W(TW)) u_comb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_shamt(in_shamt[1]),
        .in_op(in_op[1]), .in_tag(in_tag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_carry(out_carry[1]),
        .out_zero(out_zero[1]), .out_err(out_err[1]),
        .out_tag(out_tag[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {err, zero, carry, data}
    function automatic logic [18:0] model(input logic [2:0] op,
                                          input logic [15:0] d,
                                          input logic [3:0] s);
        int          n;
        logic [31:0] dd;
        logic [31:0] t;
        logic [15:0] r;
        logic        c;
        logic        e;
        n  = int'(s);
        dd = {d, d};
        c  = 1'b0;
        e  = 1'b0;
        case (op)
            3'd0: begin r = d >> n; if (n > 0) c = d[n-1]; end
            3'd1: begin r = d << n; if (n > 0) c = d[16-n]; end
            3'd2: begin r = $signed(d) >>> n; if (n > 0) c = d[n-1]; end
            3'd3: begin t = dd >> n; r = t[15:0]; if (n > 0) c = r[15]; end
            3'd4: begin t = dd << n; r = t[31:16]; if (n > 0) c = r[0]; end
            default: begin r = d; e = 1'b1; end
        endcase
        return {e, (r == 16'h0), c, r};
    endfunction

    function automatic logic [22:0] snap(input int di);
        return {out_tag[di], out_err[di], out_zero[di], out_carry[di], out_data[di]};
    endfunction

    task automatic send_one(input int di, input logic [2:0] op,
                            input logic [15:0] d, input logic [3:0] s,
                            input logic [3:0] tg,
                            output logic [22:0] res, output int lat);
        int n;
        @(posedge clk); #1;
        in_valid[di]  = 1'b1;
        in_op[di]     = op;
        in_data[di]   = d;
        in_shamt[di]  = s;
        in_tag[di]    = tg;
        out_ready[di] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[di] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid[di] = 1'b0;
        lat = -1;
        res = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid[di]) begin
                lat = c;
                res = snap(di);
                break;
            end
        end
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] d;
        logic [3:0]  s;
        logic [15:0] q;
        logic        c;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs [12];

    task automatic directed(input int di);
        logic [22:0] res;
        int          lat;
        int          exp_lat;
        logic [3:0]  tg;
        exp_lat = (di == 0) ? SW : 1;
        for (int i = 0; i < 12; i++) begin
            tg = 4'(i + 3);
            send_one(di, vecs[i].op, vecs[i].d, vecs[i].s, tg, res, lat);
            check($sformatf("d%0d_v%0d_data", di, i), 32'(res[15:0]), 32'(vecs[i].q));
            check($sformatf("d%0d_v%0d_carry", di, i), 32'(res[16]), 32'(vecs[i].c));
            check($sformatf("d%0d_v%0d_zero", di, i), 32'(res[17]), 32'(vecs[i].z));
            check($sformatf("d%0d_v%0d_err", di, i), 32'(res[18]), 32'(vecs[i].e));
            check($sformatf("d%0d_v%0d_tag", di, i), 32'(res[22:19]), 32'(tg));
            check($sformatf("d%0d_v%0d_lat", di, i), 32'(lat), 32'(exp_lat));
        end
    endtask

    task automatic reset_test(input int di);
        logic [22:0] res;
        int          lat;
        int          extra;
        @(posedge clk); #1;
        out_ready[di] = 1'b0;
        in_valid[di]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data[di]  = 16'(16'h1111 * (i + 1));
            in_op[di]    = 3'd0;
            in_shamt[di] = 4'd1;
            in_tag[di]   = 4'(i + 1);
            @(posedge clk); #1;
        end
        in_valid[di] = 1'b0;
        #2;
        check($sformatf("d%0d_pre_rst_valid", di), 32'(out_valid[di]), 32'd1);
        rst = 1'b1;
        #1;
        check($sformatf("d%0d_rst_outs", di),
              {8'h0, out_valid[di], snap(di)}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_one(di, 3'd4, 16'h00F1, 4'd4, 4'hA, res, lat);
        check($sformatf("d%0d_post_rst_res", di), 32'(res), {9'h0, 4'hA, 3'b000, 16'h0F10});
        check($sformatf("d%0d_post_rst_lat", di), 32'(lat), (di == 0) ? SW : 1);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid[di] && c > 0) extra++;
        end
        check($sformatf("d%0d_post_rst_stale", di), 32'(extra), 32'd0);
    endtask

    task automatic rand_run(input int di, input int n);
        logic [22:0] q[$];
        logic [22:0] hold;
        logic [22:0] cur;
        logic [22:0] exp;
        logic        stalled;
        logic        fire;
        int          sent;
        int          rcvd;
        int          cyc;
        int          extra;
        stalled = 1'b0;
        fire    = 1'b1;
        sent    = 0;
        rcvd    = 0;
        cyc     = 0;
        hold    = '0;
        in_valid[di] = 1'b0;
        while (rcvd < n && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (fire || !in_valid[di]) begin
                if (sent < n && ($urandom % 4) != 0) begin
                    in_valid[di] = 1'b1;
                    in_data[di]  = 16'($urandom);
                    in_shamt[di] = 4'($urandom);
                    in_tag[di]   = 4'($urandom);
                    in_op[di]    = (($urandom % 10) == 0) ?
                                   3'($urandom_range(5, 7)) :
                                   3'($urandom_range(0, 4));
                end else begin
                    in_valid[di] = 1'b0;
                end
            end
            out_ready[di] = ($urandom % 3) != 0;
            @(negedge clk);
            cur = snap(di);
            if (stalled) begin
                check($sformatf("d%0d_stall_hold", di),
                      {8'h0, out_valid[di], cur}, {8'h0, 1'b1, hold});
            end
            fire = in_valid[di] && in_ready[di];
            if (fire) begin
                q.push_back({in_tag[di], model(in_op[di], in_data[di], in_shamt[di])});
                sent++;
            end
            if (out_valid[di] && out_ready[di]) begin
                if (q.size() == 0) begin
                    check($sformatf("d%0d_rand_dup", di), 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check($sformatf("d%0d_rand_res", di), 32'(cur), 32'(exp));
                end
                rcvd++;
            end
            stalled = out_valid[di] && !out_ready[di];
            hold    = cur;
        end
        check($sformatf("d%0d_rand_count", di), 32'(rcvd), 32'(n));
        @(posedge clk); #1;
        in_valid[di]  = 1'b0;
        out_ready[di] = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid[di]) extra++;
        end
        check($sformatf("d%0d_rand_extra", di), 32'(extra), 32'd0);
        check($sformatf("d%0d_rand_left", di), 32'(q.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 16'h8001, 4'd1,  16'h4000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'd3, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'd4, 16'h8000, 4'd4,  16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd0, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd2, 16'hF0F0, 4'd0,  16'hF0F0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 16'hABCD, 4'd0,  16'hABCD, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd6, 16'h1234, 4'd5,  16'h1234, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'd3, 16'h0000, 4'd3,  16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'd2, 16'h9000, 4'd4,  16'hF900, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_shamt[i]  = '0;
            in_op[i]     = '0;
            in_tag[i]    = '0;
            out_ready[i] = 1'b1;
        end
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_reset_outs", i),
                  {8'h0, out_valid[i], snap(i)}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 2; i++) directed(i);
        for (int i = 0; i < 2; i++) rand_run(i, 100);
        for (int i = 0; i < 2; i++) reset_test(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
